// File: rtl/eth_ipv4_framer.sv
// eth_ipv4_framer: builds an IPv4 header, payload and Ethernet minimum-size pad
// into the RMII transmit FIFO, then waits for the frame and inter-frame gap.
module eth_ipv4_framer #(
  parameter logic [31:0] pSrc_Ip      = 32'hC0A80164,
  parameter logic [31:0] pDst_Ip      = 32'hC0A801FF,
  parameter logic [7:0]  pProto       = 8'h11,
  parameter logic [7:0]  pTtl         = 8'h40,
  parameter int unsigned pMax_Payload = 1480,
  parameter int unsigned pIfg_Cycles  = 48   // must be >= 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Pkt_Start,
  input  logic [10:0] Pkt_Len,
  input  logic [7:0]  Usr_Byte,
  input  logic        Usr_Byte_Valid,
  output logic        Usr_Byte_Rdy,
  input  logic        Tx_En,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Rdy,
  output logic        Busy,
  output logic        Len_Err
);

  localparam int unsigned LenW = 11;
  localparam int unsigned CntW = 16;
  localparam int unsigned SumW = 20;
  localparam logic [15:0] HdrBytes = 16'd20;
  localparam logic [15:0] MinFrame = 16'd46;

  typedef enum logic [3:0] {
    S_IDLE, S_CSUM, S_HDR, S_PAYLOAD, S_PAD, S_RDY, S_WAIT_TX, S_WAIT_DONE, S_IFG
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       tot_len_q, tot_len_d;
  logic [15:0]       id_q, id_d;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LenW-1:0]   rem_q, rem_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              len_err_q, len_err_d;

  logic [16:0]       fold1;
  logic [15:0]       fold2;
  logic [15:0]       csum;
  logic [15:0]       sum_word;
  logic [15:0]       hdr_w;

  // Header word by index; the checksum slot is supplied by the caller
  function automatic logic [15:0] hdr_word(input logic [3:0]  idx,
                                           input logic [15:0] tot_len,
                                           input logic [15:0] id,
                                           input logic [15:0] cs);
    case (idx)
      4'd0:    hdr_word = 16'h4500;
      4'd1:    hdr_word = tot_len;
      4'd2:    hdr_word = id;
      4'd3:    hdr_word = 16'h4000;
      4'd4:    hdr_word = {pTtl, pProto};
      4'd5:    hdr_word = cs;
      4'd6:    hdr_word = pSrc_Ip[31:16];
      4'd7:    hdr_word = pSrc_Ip[15:0];
      4'd8:    hdr_word = pDst_Ip[31:16];
      4'd9:    hdr_word = pDst_Ip[15:0];
      default: hdr_word = 16'h0000;
    endcase
  endfunction

  // Ones-complement checksum from the accumulated sum: two carry folds then invert
  always_comb begin
    fold1    = {1'b0, sum_q[15:0]} + 17'(sum_q[19:16]);
    fold2    = fold1[15:0] + 16'(fold1[16]);
    csum     = ~fold2;
    sum_word = hdr_word(cnt_q[3:0], tot_len_q, id_q, 16'h0000);
    hdr_w    = hdr_word(cnt_q[4:1], tot_len_q, id_q, csum);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    tot_len_d = tot_len_q;
    id_d      = id_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    byte_d    = 8'h00;
    valid_d   = 1'b0;
    rdy_d     = 1'b0;
    len_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Pkt_Start) begin
          if (Pkt_Len == '0 || Pkt_Len > LenW'(pMax_Payload)) begin
            len_err_d = 1'b1;
          end else begin
            state_d   = S_CSUM;
            tot_len_d = 16'(Pkt_Len) + HdrBytes;
            rem_d     = Pkt_Len;
            sum_d     = '0;
            cnt_d     = '0;
          end
        end
      end
      S_CSUM: begin
        sum_d = sum_q + SumW'(sum_word);
        if (cnt_q == CntW'(9)) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_HDR: begin
        valid_d = 1'b1;
        byte_d  = cnt_q[0] ? hdr_w[7:0] : hdr_w[15:8];
        if (cnt_q == CntW'(19)) begin
          state_d = S_PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_PAYLOAD: begin
        if (Usr_Byte_Valid) begin
          valid_d = 1'b1;
          byte_d  = Usr_Byte;
          rem_d   = rem_q - LenW'(1);
          if (rem_q == LenW'(1)) begin
            if (tot_len_q < MinFrame) begin
              state_d = S_PAD;
              cnt_d   = CntW'(MinFrame - tot_len_q);
            end else begin
              state_d = S_RDY;
            end
          end
        end
      end
      S_PAD: begin
        valid_d = 1'b1;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = S_RDY;
      end
      S_RDY: begin
        rdy_d   = 1'b1;
        id_d    = id_q + 16'd1;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (Tx_En) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!Tx_En) begin
          state_d = S_IFG;
          cnt_d   = CntW'(pIfg_Cycles - 1);
        end
      end
      S_IFG: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      tot_len_q <= '0;
      id_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tot_len_q <= tot_len_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
    end
  end

  assign Usr_Byte_Rdy   = (state_q == S_PAYLOAD);
  assign Eth_Byte       = byte_q;
  assign Eth_Byte_Valid = valid_q;
  assign Eth_Pkt_Rdy    = rdy_q;
  assign Busy           = busy_q;
  assign Len_Err        = len_err_q;

endmodule
